// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS control FSM: state codes,
// opcode/funct values, datapath select encodings and the control-word struct
// the FSM decodes each cycle. Also small decode helpers used by the FSM.
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

  // State codes are plain 5-bit constants so state_o matches the legacy
  // debug encoding.
  localparam logic [4:0] S_SP_SET    = 5'd0;
  localparam logic [4:0] S_FETCH     = 5'd1;
  localparam logic [4:0] S_DECODE    = 5'd2;
  localparam logic [4:0] S_R_EXEC    = 5'd3;
  localparam logic [4:0] S_WB_ALU    = 5'd4;
  localparam logic [4:0] S_SHIFT1    = 5'd5;
  localparam logic [4:0] S_SHIFT2    = 5'd6;
  localparam logic [4:0] S_WB_SHIFT  = 5'd7;
  localparam logic [4:0] S_JR        = 5'd8;
  localparam logic [4:0] S_ADDI_EXEC = 5'd9;
  localparam logic [4:0] S_WB_IMM    = 5'd10;
  localparam logic [4:0] S_WB_LUI    = 5'd11;
  localparam logic [4:0] S_ADDR      = 5'd12;
  localparam logic [4:0] S_MEM_RD    = 5'd13;
  localparam logic [4:0] S_WB_MEM    = 5'd14;
  localparam logic [4:0] S_MEM_WR    = 5'd15;
  localparam logic [4:0] S_BR        = 5'd16;
  localparam logic [4:0] S_JUMP      = 5'd17;
  localparam logic [4:0] S_JAL       = 5'd18;
  localparam logic [4:0] S_EXC       = 5'd19;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Function codes (IR[5:0]) for R-type
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;

  // ALU operation codes
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;

  // ALU B-operand selects
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // PC source selects
  localparam logic [1:0] PC_ALU  = 2'd0;
  localparam logic [1:0] PC_A    = 2'd1;
  localparam logic [1:0] PC_JUMP = 2'd2;
  localparam logic [1:0] PC_EXC  = 2'd3;

  // Register-destination selects
  localparam logic [1:0] RD_RT  = 2'd0;
  localparam logic [1:0] RD_RD  = 2'd1;
  localparam logic [1:0] RD_R29 = 2'd2;
  localparam logic [1:0] RD_R31 = 2'd3;

  // Write-back data selects
  localparam logic [2:0] WB_MDR    = 3'd0;
  localparam logic [2:0] WB_ALUOUT = 3'd1;
  localparam logic [2:0] WB_LUI    = 3'd2;
  localparam logic [2:0] WB_SHIFT  = 3'd5;
  localparam logic [2:0] WB_SP     = 3'd6;

  // Memory access sizes
  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;

  // Shifter operations
  localparam logic [2:0] SH_IDLE = 3'd0;
  localparam logic [2:0] SH_LOAD = 3'd1;
  localparam logic [2:0] SH_SLL  = 3'd2;
  localparam logic [2:0] SH_SRL  = 3'd3;
  localparam logic [2:0] SH_SRA  = 3'd4;

  // Exception causes
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_OVF     = 2'd2;

  // One cycle's worth of datapath control.
  typedef struct packed {
    logic       pc_load;
    logic       ir_load;
    logic       mdr_load;
    logic       a_load;
    logic       b_load;
    logic       aluout_load;
    logic       reg_write;
    logic       mem_write;
    logic       iord;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [2:0] alu_op;
    logic [1:0] pcsrc;
    logic [1:0] regdst;
    logic [2:0] mem2reg;
    logic [2:0] shift_op;
    logic       shift_amt_sel;
    logic       epc_load;
  } ctrl_t;

  // Access size implied by a load/store opcode; word for everything else.
  function automatic logic [1:0] size_of(input logic [5:0] op);
    case (op)
      OP_LB, OP_SB: size_of = SZ_BYTE;
      OP_LH, OP_SH: size_of = SZ_HALF;
      default:      size_of = SZ_WORD;
    endcase
  endfunction

  // ALU op for the arithmetic/logic R-type functs.
  function automatic logic [2:0] r_alu_op(input logic [5:0] fn);
    case (fn)
      F_ADD:   r_alu_op = ALU_ADD;
      F_SUB:   r_alu_op = ALU_SUB;
      F_AND:   r_alu_op = ALU_AND;
      F_OR:    r_alu_op = ALU_OR;
      F_SLT:   r_alu_op = ALU_SLT;
      default: r_alu_op = ALU_PASS;
    endcase
  endfunction

  function automatic logic is_alu_funct(input logic [5:0] fn);
    is_alu_funct = (fn == F_ADD) || (fn == F_SUB) || (fn == F_AND) ||
                   (fn == F_OR)  || (fn == F_SLT);
  endfunction

  function automatic logic is_shift_funct(input logic [5:0] fn);
    is_shift_funct = (fn == F_SLL) || (fn == F_SRL) || (fn == F_SRA) ||
                     (fn == F_SLLV) || (fn == F_SRAV);
  endfunction

  function automatic logic [2:0] shift_code(input logic [5:0] fn);
    case (fn)
      F_SLL, F_SLLV: shift_code = SH_SLL;
      F_SRL:         shift_code = SH_SRL;
      F_SRA, F_SRAV: shift_code = SH_SRA;
      default:       shift_code = SH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_ctr.sv
// -----------------------------------------------------------------------------
// mc_wait_ctr
// Memory-latency counter. Loads a start value, counts down to zero and holds
// there; o_done is high while the count is zero.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (count <= RST_VAL)
//   i_load       load i_load_val this cycle (wins over counting)
//   i_load_val   start value, MEM_LAT-1 for an access of MEM_LAT cycles
//   o_done       count == 0
// -----------------------------------------------------------------------------
module mc_wait_ctr #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the reset branch sits in the sensitivity list to make
  // it asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
// Multicycle MIPS control FSM for the single-memory datapath. Decodes the IR
// opcode/funct and ALU flags and drives every load enable and mux select.
// Memory accesses (fetch, load, store) wait MEM_LAT cycles via mc_wait_ctr.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   opcode, funct            IR[31:26], IR[5:0]
//   alu_zero, alu_ovf        ALU flags of the current operation
//   pc_load .. epc_load      datapath write enables and mux selects
//   size_ctrl                registered load/store size
//   cause                    registered exception cause, held until the next
//   state_o                  current state (debug)
// -----------------------------------------------------------------------------
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 3,
  parameter int SP_INIT = 1,
  parameter int EXC_EN  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  output logic       pc_load,
  output logic       ir_load,
  output logic       mdr_load,
  output logic       a_load,
  output logic       b_load,
  output logic       aluout_load,
  output logic       reg_write,
  output logic       mem_write,
  output logic       iord,
  output logic       alusrc_a,
  output logic [1:0] alusrc_b,
  output logic [2:0] alu_op,
  output logic [1:0] pcsrc,
  output logic [1:0] regdst,
  output logic [2:0] mem2reg,
  output logic [1:0] size_ctrl,
  output logic [2:0] shift_op,
  output logic       shift_amt_sel,
  output logic       epc_load,
  output logic [1:0] cause,
  output logic [4:0] state_o
);

  localparam logic [4:0] RST_STATE = (SP_INIT != 0) ? S_SP_SET : S_FETCH;
  localparam logic [3:0] LAT_M1    = 4'(MEM_LAT - 1);
  localparam bit         EXC_ON    = (EXC_EN != 0);
  // Without the SP_SET cycle the FSM wakes up directly in FETCH, so the
  // counter must already hold a full fetch wait out of reset.
  localparam logic [3:0] CTR_RST   = (SP_INIT != 0) ? 4'd0 : LAT_M1;

  logic [4:0] r_state;
  logic [1:0] r_size;
  logic [1:0] r_cause;
  logic [4:0] w_next;
  logic [1:0] w_exc_cause;
  logic       w_done;
  logic       w_ctr_load;
  ctrl_t      w_ctrl;

  // The counter is armed on entry to any memory state; the FSM leaves that
  // state on the cycle the count reaches zero.
  assign w_ctr_load = ((w_next == S_FETCH) || (w_next == S_MEM_RD) ||
                       (w_next == S_MEM_WR)) && (w_next != r_state);

  mc_wait_ctr #(
    .W       (4),
    .RST_VAL (CTR_RST)
  ) u_wait (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_ctr_load),
    .i_load_val (LAT_M1),
    .o_done     (w_done)
  );

  // Next-state logic
  // NOTE: every variable assigned in a combinational block gets a default at
  // the top, so no path through the case statements can infer a latch.
  always_comb begin
    w_next      = r_state;
    w_exc_cause = CAUSE_NONE;
    case (r_state)
      S_SP_SET: w_next = S_FETCH;
      S_FETCH:  if (w_done) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:            w_next = S_R_EXEC;
          OP_ADDI:             w_next = S_ADDI_EXEC;
          OP_LUI:              w_next = S_WB_LUI;
          OP_LW, OP_LH, OP_LB,
          OP_SW, OP_SH, OP_SB: w_next = S_ADDR;
          OP_BEQ, OP_BNE:      w_next = S_BR;
          OP_J:                w_next = S_JUMP;
          OP_JAL:              w_next = S_JAL;
          default: begin
            w_next      = EXC_ON ? S_EXC : S_FETCH;
            w_exc_cause = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_R_EXEC: begin
        if (is_alu_funct(funct)) begin
          if (EXC_ON && alu_ovf && ((funct == F_ADD) || (funct == F_SUB))) begin
            w_next      = S_EXC;
            w_exc_cause = CAUSE_OVF;
          end else begin
            w_next = S_WB_ALU;
          end
        end else if (is_shift_funct(funct)) begin
          w_next = S_SHIFT1;
        end else if (funct == F_JR) begin
          w_next = S_JR;
        end else begin
          w_next      = EXC_ON ? S_EXC : S_FETCH;
          w_exc_cause = CAUSE_ILLEGAL;
        end
      end
      S_SHIFT1: w_next = S_SHIFT2;
      S_SHIFT2: w_next = S_WB_SHIFT;
      S_ADDI_EXEC: begin
        if (EXC_ON && alu_ovf) begin
          w_next      = S_EXC;
          w_exc_cause = CAUSE_OVF;
        end else begin
          w_next = S_WB_IMM;
        end
      end
      // Address calculation never traps: overflow here is deliberately ignored.
      S_ADDR:   w_next = opcode[3] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (w_done) w_next = S_WB_MEM;
      S_MEM_WR: if (w_done) w_next = S_FETCH;
      S_JAL:    w_next = S_JUMP;
      S_WB_ALU, S_WB_SHIFT, S_WB_IMM, S_WB_LUI, S_WB_MEM,
      S_JR, S_BR, S_JUMP, S_EXC: w_next = S_FETCH;
      default:  w_next = RST_STATE;
    endcase
  end

  // Moore control decode from the registered state (R-type selects also
  // look at funct, which is stable in the IR for the whole instruction).
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_SP_SET: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.regdst    = RD_R29;
        w_ctrl.mem2reg   = WB_SP;
      end
      S_FETCH: begin
        w_ctrl.alusrc_b = SRCB_FOUR;
        w_ctrl.alu_op   = ALU_ADD;
        w_ctrl.pcsrc    = PC_ALU;
        w_ctrl.ir_load  = w_done;
        w_ctrl.pc_load  = w_done;
      end
      S_DECODE: begin
        w_ctrl.a_load      = 1'b1;
        w_ctrl.b_load      = 1'b1;
        w_ctrl.aluout_load = 1'b1;
        w_ctrl.alusrc_b    = SRCB_IMM_SH;
        w_ctrl.alu_op      = ALU_ADD;
      end
      S_R_EXEC: begin
        w_ctrl.alusrc_a    = 1'b1;
        w_ctrl.alusrc_b    = SRCB_B;
        w_ctrl.alu_op      = r_alu_op(funct);
        w_ctrl.aluout_load = is_alu_funct(funct);
      end
      S_WB_ALU: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.regdst    = RD_RD;
        w_ctrl.mem2reg   = WB_ALUOUT;
      end
      S_SHIFT1: begin
        w_ctrl.shift_op      = SH_LOAD;
        w_ctrl.shift_amt_sel = (funct == F_SLLV) || (funct == F_SRAV);
      end
      S_SHIFT2: begin
        w_ctrl.shift_op      = shift_code(funct);
        w_ctrl.shift_amt_sel = (funct == F_SLLV) || (funct == F_SRAV);
      end
      S_WB_SHIFT: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.regdst    = RD_RD;
        w_ctrl.mem2reg   = WB_SHIFT;
      end
      S_JR: begin
        w_ctrl.pcsrc   = PC_A;
        w_ctrl.pc_load = 1'b1;
      end
      S_ADDI_EXEC, S_ADDR: begin
        w_ctrl.alusrc_a    = 1'b1;
        w_ctrl.alusrc_b    = SRCB_IMM;
        w_ctrl.alu_op      = ALU_ADD;
        w_ctrl.aluout_load = 1'b1;
      end
      S_WB_IMM: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.regdst    = RD_RT;
        w_ctrl.mem2reg   = WB_ALUOUT;
      end
      S_WB_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.regdst    = RD_RT;
        w_ctrl.mem2reg   = WB_LUI;
      end
      S_MEM_RD: begin
        w_ctrl.iord     = 1'b1;
        w_ctrl.mdr_load = w_done;
      end
      S_WB_MEM: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.regdst    = RD_RT;
        w_ctrl.mem2reg   = WB_MDR;
      end
      S_MEM_WR: begin
        w_ctrl.iord      = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      S_BR: begin
        w_ctrl.alusrc_a = 1'b1;
        w_ctrl.alusrc_b = SRCB_B;
        w_ctrl.alu_op   = ALU_SUB;
        w_ctrl.pcsrc    = PC_ALU;
        w_ctrl.pc_load  = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;
      end
      S_JUMP: begin
        w_ctrl.pcsrc   = PC_JUMP;
        w_ctrl.pc_load = 1'b1;
      end
      S_JAL: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.regdst    = RD_R31;
        w_ctrl.mem2reg   = WB_ALUOUT;
      end
      S_EXC: begin
        w_ctrl.epc_load = 1'b1;
        w_ctrl.pcsrc    = PC_EXC;
        w_ctrl.pc_load  = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
    // Reset kills every strobe immediately, even mid-access, without waiting
    // for a clock edge (SP_SET would otherwise assert reg_write during reset).
    if (rst) w_ctrl = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_STATE;
      r_size  <= SZ_WORD;
      r_cause <= CAUSE_NONE;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_size <= size_of(opcode);
      if (w_next == S_EXC)     r_cause <= w_exc_cause;
    end
  end

  assign pc_load       = w_ctrl.pc_load;
  assign ir_load       = w_ctrl.ir_load;
  assign mdr_load      = w_ctrl.mdr_load;
  assign a_load        = w_ctrl.a_load;
  assign b_load        = w_ctrl.b_load;
  assign aluout_load   = w_ctrl.aluout_load;
  assign reg_write     = w_ctrl.reg_write;
  assign mem_write     = w_ctrl.mem_write;
  assign iord          = w_ctrl.iord;
  assign alusrc_a      = w_ctrl.alusrc_a;
  assign alusrc_b      = w_ctrl.alusrc_b;
  assign alu_op        = w_ctrl.alu_op;
  assign pcsrc         = w_ctrl.pcsrc;
  assign regdst        = w_ctrl.regdst;
  assign mem2reg       = w_ctrl.mem2reg;
  assign shift_op      = w_ctrl.shift_op;
  assign shift_amt_sel = w_ctrl.shift_amt_sel;
  assign epc_load      = w_ctrl.epc_load;
  assign size_ctrl     = r_size;
  assign cause         = r_cause;
  assign state_o       = r_state;

endmodule
